// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_MFHI  = 4'd0;
  localparam logic [3:0] MD_MFLO  = 4'd1;
  localparam logic [3:0] MD_MTHI  = 4'd2;
  localparam logic [3:0] MD_MTLO  = 4'd3;
  localparam logic [3:0] MD_MULTU = 4'd4;
  localparam logic [3:0] MD_DIVU  = 4'd5;
  localparam logic [3:0] MD_MULT  = 4'd6;
  localparam logic [3:0] MD_DIV   = 4'd7;
  localparam logic [3:0] MD_MADD  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MSUB  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX
  } md_state_t;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle after load,
// done once all WIDTH bits have been produced.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // The dividend shifts out of r_quo into the partial remainder as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done      = (r_cnt == '0);

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, iterative signed/unsigned divide and flush.
// Define MD_MADD_EN to enable the multiply-accumulate/subtract op codes (8-11).
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  localparam int CW = $clog2(MUL_LAT + WIDTH + 1);

  md_state_t          r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
`ifdef MD_MADD_EN
  logic               r_acc;
  logic               r_sub;
`endif

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_done;
  logic               w_div_load;

  assign w_accept = start && !r_busy && !flush;
  assign w_is_div = (op == MD_DIVU) || (op == MD_DIV);
`ifdef MD_MADD_EN
  assign w_is_mul = (op == MD_MULTU) || (op == MD_MULT) || is_acc_op(op);
`else
  assign w_is_mul = (op == MD_MULTU) || (op == MD_MULT);
`endif

  // Extending both operands to 2*WIDTH makes the truncated product correct for either signedness.
  assign w_ext_a = is_signed_op(op) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign w_ext_b = is_signed_op(op) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign w_prod  = w_ext_a * w_ext_b;

  // The accumulate path reads HI:LO at completion, so MTHI/MTLO history up to then is honoured.
`ifdef MD_MADD_EN
  assign w_mul_res = !r_acc ? r_prod :
                     r_sub  ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);
`else
  assign w_mul_res = r_prod;
`endif

  assign w_abs_a    = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b    = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
  assign w_div_load = (r_state == DIV_PREP);

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (w_div_load),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_prod   <= '0;
      r_cnt    <= '0;
`ifdef MD_MADD_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
`endif
    end else if (flush && (r_state != IDLE)) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (op == MD_MTHI) r_hi <= a;
            if (op == MD_MTLO) r_lo <= a;
            if (w_is_mul) begin
              r_state <= MUL;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(MUL_LAT - 1);
              r_prod  <= w_prod;
`ifdef MD_MADD_EN
              r_acc   <= is_acc_op(op);
              r_sub   <= (op == MD_MSUB) || (op == MD_MSUBU);
`endif
            end else if (w_is_div) begin
              r_state  <= DIV_PREP;
              r_busy   <= 1'b1;
              r_a      <= a;
              r_b      <= b;
              r_signed <= (op == MD_DIV);
            end
          end
        end
        MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DIV_PREP: begin
          r_neg_q <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= r_signed && r_a[WIDTH-1];
          r_cnt   <= CW'(WIDTH - 1);
          r_state <= DIV_ITER;
        end
        DIV_ITER: begin
          if (r_cnt == '0) r_state <= DIV_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        DIV_FIX: begin
          // Divide by zero returns all-ones / dividend rather than the raw divider output.
          if (r_b == '0) begin
            r_lo <= '1;
            r_hi <= r_a;
          end else if (w_div_done) begin
            r_lo <= r_neg_q ? -w_quo : w_quo;
            r_hi <= r_neg_r ? -w_rem : w_rem;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = (op == MD_MFHI) ? r_hi : (op == MD_MFLO) ? r_lo : '0;
  assign busy  = r_busy;

endmodule

// File: tb/tb_md_unit.sv
// Randomized and directed bench for md_unit against an arithmetic HI/LO reference model.
module tb_md_unit;

  localparam int W  = 32;
  localparam int ML = 5;

  logic          clk;
  logic          reset;
  logic [3:0]    op;
  logic          start;
  logic          flush;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  rdata;
  logic          busy;

  int            n_total;
  int            n_bad;
  logic [W-1:0]  m_hi;
  logic [W-1:0]  m_lo;

  md_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .start (start),
    .flush (flush),
    .a     (a),
    .b     (b),
    .rdata (rdata),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply one accepted op to m_hi/m_lo with plain arithmetic; return busy length.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    logic [63:0] p;
    logic [63:0] acc;
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    lat = 0;
    sx  = $signed(x);
    sy  = $signed(y);
    p   = 64'd0;
    acc = 64'd0;
    case (o)
      4'd2: m_hi = x;
      4'd3: m_lo = x;
      4'd4: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; lat = ML; end
      4'd6: begin p = sx * sy; {m_hi, m_lo} = p; lat = ML; end
      4'd5: begin
        lat = W + 2;
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
      4'd7: begin
        lat = W + 2;
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
`ifdef MD_MADD_EN
      4'd8, 4'd9, 4'd10, 4'd11: begin
        lat = ML;
        if (o == 4'd8 || o == 4'd10) p = sx * sy;
        else p = {32'd0, x} * {32'd0, y};
        acc = {m_hi, m_lo};
        acc = (o <= 4'd9) ? acc + p : acc - p;
        {m_hi, m_lo} = acc;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int           lat;
    int           cnt;
    logic [W-1:0] old_lo;
    old_lo = m_lo;
    model(o, x, y, lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 4'd1;
    #1;
    cnt = 0;
    if (lat == 0) begin
      chk("busy_stays_low", {63'd0, busy}, 64'd0);
    end else begin
      chk("old_lo_while_busy", {32'd0, rdata}, {32'd0, old_lo});
      while (busy && cnt < 200) begin
        cnt++;
        tick();
      end
      chk("busy_cycles", 64'(cnt), 64'(lat));
    end
    op = 4'd0;
    #1;
    chk("hi", {32'd0, rdata}, {32'd0, m_hi});
    op = 4'd1;
    #1;
    chk("lo", {32'd0, rdata}, {32'd0, m_lo});
    $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", o, x, y, cnt, m_hi, m_lo);
  endtask

  initial begin
    logic [3:0] ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_total = 0;
    n_bad   = 0;
    m_hi    = '0;
    m_lo    = '0;
    reset = 1'b0; op = 4'd0; start = 1'b0; flush = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_mfhi", {32'd0, rdata}, 64'd0);
    op = 4'd1; #1;
    chk("reset_mflo", {32'd0, rdata}, 64'd0);
    op = 4'd5; #1;
    chk("reset_other_op", {32'd0, rdata}, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    do_op(4'd2, 32'h1234_5678, 32'd0);
    do_op(4'd3, 32'h9ABC_DEF0, 32'd0);
    do_op(4'd6, -32'sd3, 32'd7);
    do_op(4'd7, -32'sd7, 32'd2);
    do_op(4'd5, 32'd7, 32'd0);
    do_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(4'd4, 32'd3, 32'd4);

    // Flush mid-divide, with an ignored start while busy.
    op = 4'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (4) tick();
    op = 4'd2; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    op = 4'd0; #1;
    chk("flush_hi", {32'd0, rdata}, {32'd0, m_hi});
    op = 4'd1; #1;
    chk("flush_lo", {32'd0, rdata}, {32'd0, m_lo});
    $display("flush during divu: hi=%h lo=%h", m_hi, m_lo);

    op = 4'd4; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {63'd0, busy}, 64'd0);
    op = 4'd3; a = 32'h5555_AAAA; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    repeat (ML + 1) tick();
    op = 4'd1; #1;
    chk("start_flush_lo", {32'd0, rdata}, {32'd0, m_lo});
    $display("start with flush: lo=%h", m_lo);

`ifdef MD_MADD_EN
    do_op(4'd2, 32'd0, 32'd0);
    do_op(4'd3, 32'd10, 32'd0);
    do_op(4'd8, 32'd2, 32'd3);
    do_op(4'd11, 32'd5, 32'd4);
`else
    do_op(4'd8, 32'd2, 32'd3);
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'(ra[3:0]) : $urandom;
      if (i % 7 == 0) rb = '0;
      if (i % 11 == 3) begin ro = 4'd7; ra = 32'h8000_0000; rb = '1; end
      do_op(ro, ra, rb);
    end

    // Asynchronous reset discards an in-flight divide.
    op = 4'd7; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    op = 4'd0; #1;
    chk("async_reset_hi", {32'd0, rdata}, 64'd0);
    op = 4'd1; #1;
    chk("async_reset_lo", {32'd0, rdata}, 64'd0);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    $display("async reset mid-divide");
    tick();
    do_op(4'd5, 32'd100, 32'd7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
